// File: rtl/svc_cdc_sync_filt.sv
// svc_cdc_sync_filt: per-bit multi-flop synchronizer with an optional
// stability filter and registered rise/fall/change edge pulses.

// One bit: synchronizer chain, optional filter and edge pulses.
module svc_cdc_sync_filt_bit #(
    parameter int   STAGES  = 2,
    parameter int   FILTER  = 0,
    parameter logic RST_BIT = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] sync;
    logic              s;

    assign s = sync[STAGES-1];

    // Synchronizer chain: stage 0 samples the asynchronous input.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sync <= {STAGES{RST_BIT}};
        else        sync <= {sync[STAGES-2:0], d};
    end

    generate
        if (FILTER == 0) begin : g_nofilt
            assign q = s;

            // Pulses are computed from the stage feeding s so they line up
            // with the edge on which s (and therefore q) changes.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    rise <= 1'b0;
                    fall <= 1'b0;
                end else begin
                    rise <= sync[STAGES-2] & ~s;
                    fall <= ~sync[STAGES-2] & s;
                end
            end
        end else begin : g_filt
            localparam int            CW   = (FILTER < 2) ? 1 : $clog2(FILTER + 1);
            localparam logic [CW-1:0] CMAX = CW'(FILTER - 1);

            logic [CW-1:0] cnt;
            logic          q_r;

            assign q = q_r;

            // Filter: q takes s only after FILTER consecutive mismatching
            // edges; any agreement restarts the count, so it never wraps.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    cnt  <= '0;
                    q_r  <= RST_BIT;
                    rise <= 1'b0;
                    fall <= 1'b0;
                end else begin
                    rise <= 1'b0;
                    fall <= 1'b0;
                    if (s == q_r) begin
                        cnt <= '0;
                    end else if (cnt == CMAX) begin
                        cnt  <= '0;
                        q_r  <= s;
                        rise <= s;
                        fall <= ~s;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
            end
        end
    endgenerate

endmodule

// Top: WIDTH independent bit slices.
module svc_cdc_sync_filt #(
    parameter int               WIDTH   = 1,
    parameter int               STAGES  = 2,
    parameter int               FILTER  = 0,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall,
    output logic [WIDTH-1:0] change
);

    generate
        for (genvar i = 0; i < WIDTH; i++) begin : g_bit
            svc_cdc_sync_filt_bit #(
                .STAGES  (STAGES),
                .FILTER  (FILTER),
                .RST_BIT (RST_VAL[i])
            ) u_bit (
                .clk   (clk),
                .rst_n (rst_n),
                .d     (d[i]),
                .q     (q[i]),
                .rise  (rise[i]),
                .fall  (fall[i])
            );
        end
    endgenerate

    assign change = rise | fall;

endmodule

// File: tb/tb_svc_cdc_sync_filt.sv
// Directed bench for svc_cdc_sync_filt across several parameter sets.
module tb_svc_cdc_sync_filt;

    logic clk = 1'b0;
    int   total = 0;
    int   bad   = 0;

    logic       rst0, rst1, rst2, rst3, rst4;
    logic       d0, d1, d3, d4;
    logic [3:0] d2;
    logic       q0, r0, f0, c0;
    logic       q1, r1, f1, c1;
    logic [3:0] q2, r2, f2, c2;
    logic       q3, r3, f3, c3;
    logic       q4, r4, f4, c4;

    always #5 clk = ~clk;

    svc_cdc_sync_filt #(.WIDTH(1), .STAGES(2), .FILTER(0), .RST_VAL(1'b0)) u0 (
        .clk(clk), .rst_n(rst0), .d(d0), .q(q0), .rise(r0), .fall(f0), .change(c0));
    svc_cdc_sync_filt #(.WIDTH(1), .STAGES(3), .FILTER(4), .RST_VAL(1'b0)) u1 (
        .clk(clk), .rst_n(rst1), .d(d1), .q(q1), .rise(r1), .fall(f1), .change(c1));
    svc_cdc_sync_filt #(.WIDTH(4), .STAGES(2), .FILTER(0), .RST_VAL(4'b0000)) u2 (
        .clk(clk), .rst_n(rst2), .d(d2), .q(q2), .rise(r2), .fall(f2), .change(c2));
    svc_cdc_sync_filt #(.WIDTH(1), .STAGES(2), .FILTER(0), .RST_VAL(1'b1)) u3 (
        .clk(clk), .rst_n(rst3), .d(d3), .q(q3), .rise(r3), .fall(f3), .change(c3));
    svc_cdc_sync_filt #(.WIDTH(1), .STAGES(2), .FILTER(1), .RST_VAL(1'b0)) u4 (
        .clk(clk), .rst_n(rst4), .d(d4), .q(q4), .rise(r4), .fall(f4), .change(c4));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    initial begin
        logic dh [0:15];
        logic qe, qp;

        rst0 = 0; rst1 = 0; rst2 = 0; rst3 = 0; rst4 = 0;
        d0 = 0; d1 = 0; d2 = '0; d3 = 0; d4 = 0;

        // Reset state, and outputs held while d moves during reset
        tick(); tick();
        chk("rst_q0", {3'b0, q0}, 4'h0);
        chk("rst_q1", {3'b0, q1}, 4'h0);
        chk("rst_q2", q2, 4'h0);
        chk("rst_q3", {3'b0, q3}, 4'h1);
        chk("rst_pulses", {r0, f0, r3, f3}, 4'h0);
        d0 = 1;
        tick(); tick(); tick();
        chk("rst_hold_q0", {3'b0, q0}, 4'h0);
        chk("rst_hold_q3", {3'b0, q3}, 4'h1);
        chk("rst_hold_r0", {3'b0, r0}, 4'h0);

        // u0 rise after 2 edges; u3 (RST_VAL=1, d=0) falls after 2 edges
        rst0 = 1; rst1 = 1; rst2 = 1; rst3 = 1; rst4 = 1;
        tick();
        chk("e1_q0", {3'b0, q0}, 4'h0);
        chk("e1_r0", {3'b0, r0}, 4'h0);
        chk("e1_q3", {3'b0, q3}, 4'h1);
        chk("e1_f3", {3'b0, f3}, 4'h0);
        tick();
        chk("e2_q0", {3'b0, q0}, 4'h1);
        chk("e2_r0", {3'b0, r0}, 4'h1);
        chk("e2_f0", {3'b0, f0}, 4'h0);
        chk("e2_q3", {3'b0, q3}, 4'h0);
        chk("e2_f3", {3'b0, f3}, 4'h1);
        chk("e2_c3", {3'b0, c3}, 4'h1);
        tick();
        chk("e3_r0", {3'b0, r0}, 4'h0);
        chk("e3_q0", {3'b0, q0}, 4'h1);
        chk("e3_f0", {3'b0, f0}, 4'h0);
        chk("e3_f3", {3'b0, f3}, 4'h0);

        // Multi-bit: independent per-bit pulses in the same cycle
        d2 = 4'b0101;
        tick();
        chk("w_e1_r2", r2, 4'b0000);
        tick();
        chk("w_e2_q2", q2, 4'b0101);
        chk("w_e2_r2", r2, 4'b0101);
        chk("w_e2_f2", f2, 4'b0000);
        tick();
        chk("w_e3_r2", r2, 4'b0000);
        d2 = 4'b0011;
        tick(); tick();
        chk("w2_q2", q2, 4'b0011);
        chk("w2_r2", r2, 4'b0010);
        chk("w2_f2", f2, 4'b0100);
        chk("w2_c2", c2, 4'b0110);
        tick();
        chk("w3_c2", c2, 4'b0000);

        // Filter: 3-cycle glitch on d is suppressed
        d1 = 1;
        tick(); tick(); tick();
        d1 = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("glitch_q1", {3'b0, q1}, 4'h0);
            chk("glitch_c1", {3'b0, c1}, 4'h0);
        end

        // Filter: reset asserted at count 2 aborts the pending update
        d1 = 1;
        tick(); tick(); tick(); tick(); tick();
        rst1 = 0;
        #1;
        chk("midrst_q1", {3'b0, q1}, 4'h0);
        chk("midrst_c1", {3'b0, c1}, 4'h0);
        tick();
        rst1 = 1;
        // Full STAGES+FILTER = 7 edge latency after release
        for (int i = 1; i <= 6; i++) begin
            tick();
            chk("lat_q1", {3'b0, q1}, 4'h0);
            chk("lat_r1", {3'b0, r1}, 4'h0);
        end
        tick();
        chk("lat7_q1", {3'b0, q1}, 4'h1);
        chk("lat7_r1", {3'b0, r1}, 4'h1);
        tick();
        chk("lat8_r1", {3'b0, r1}, 4'h0);
        chk("lat8_q1", {3'b0, q1}, 4'h1);
        d1 = 0;
        for (int i = 1; i <= 6; i++) tick();
        chk("fall6_q1", {3'b0, q1}, 4'h1);
        tick();
        chk("fall7_q1", {3'b0, q1}, 4'h0);
        chk("fall7_f1", {3'b0, f1}, 4'h1);
        tick();
        chk("fall8_f1", {3'b0, f1}, 4'h0);

        // FILTER=1: d toggles every 2 cycles, q lags by 3 edges
        qp = 0;
        for (int n = 1; n <= 14; n++) begin
            d4 = (n <= 10) ? (((n - 1) / 2) % 2 == 0) : 1'b0;
            dh[n] = d4;
            tick();
            qe = (n >= 3) ? dh[n-2] : 1'b0;
            chk("alt_q4", {3'b0, q4}, {3'b0, qe});
            chk("alt_r4", {3'b0, r4}, {3'b0, qe & ~qp});
            chk("alt_f4", {3'b0, f4}, {3'b0, ~qe & qp});
            qp = qe;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
